// File: rtl/pwr_pkg.sv
// Shared constants and state encoding for the power-averaging datapath and the
// multiplier-side sequencer.
package pwr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } pwr_state_e;

  localparam int PWR_DW       = 12;
  localparam int PWR_LOG2_N   = 4;
  localparam int PWR_OVER_CNT = 3;
  // Over-counter width covers the full legal OVER_CNT range 1..15.
  localparam int PWR_OVER_W   = 4;

  // Increment that sticks at lim once reached.
  function automatic logic [PWR_OVER_W-1:0] sat_inc(
    input logic [PWR_OVER_W-1:0] value,
    input logic [PWR_OVER_W-1:0] lim
  );
    return (value >= lim) ? lim : value + PWR_OVER_W'(1);
  endfunction

endpackage

// File: rtl/pwr_alarm_deb.sv
// Debounced sticky over-power alarm: counts consecutive over-threshold windows
// and latches the alarm once OVER_CNT are seen in a row.
module pwr_alarm_deb
  import pwr_pkg::*;
#(
  parameter int OVER_CNT = PWR_OVER_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic win_done,
  input  logic over,
  input  logic alarm_clr,
  input  logic en,
  output logic alarm
);

  localparam logic [PWR_OVER_W-1:0] LIM = PWR_OVER_W'(OVER_CNT);

  logic [PWR_OVER_W-1:0] cnt_reg;
  logic [PWR_OVER_W-1:0] cnt_next;
  logic [PWR_OVER_W-1:0] cnt_inc;
  logic                  alarm_reg;
  logic                  alarm_next;

  always_comb begin
    cnt_inc    = sat_inc(cnt_reg, LIM);
    cnt_next   = cnt_reg;
    alarm_next = alarm_reg;
    if (!en) begin
      cnt_next = '0;
      if (alarm_clr) alarm_next = 1'b0;
    end else if (win_done && over && (cnt_inc == LIM)) begin
      // A setting window takes priority over a coincident clear.
      cnt_next   = LIM;
      alarm_next = 1'b1;
    end else if (alarm_clr) begin
      cnt_next   = '0;
      alarm_next = 1'b0;
    end else if (win_done) begin
      cnt_next = over ? cnt_inc : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      alarm_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      alarm_reg <= alarm_next;
    end
  end

  assign alarm = alarm_reg;

endmodule

// File: rtl/pwr_avg_alarm.sv
// Block-averages multiplier products over 2^LOG2_N samples, tracks the peak
// sample and drives a debounced over-power alarm from the window averages.
module pwr_avg_alarm
  import pwr_pkg::*;
#(
  parameter int DW       = PWR_DW,
  parameter int LOG2_N   = PWR_LOG2_N,
  parameter int OVER_CNT = PWR_OVER_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DW-1:0]     sample_in,
  input  logic              sample_vld,
  input  logic [DW-1:0]     thr,
  input  logic              peak_clr,
  input  logic              alarm_clr,
  output logic [DW-1:0]     avg_out,
  output logic              avg_vld,
  output logic [DW-1:0]     peak_out,
  output logic              alarm,
  output logic [LOG2_N-1:0] win_cnt
);

  localparam int AW = DW + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST = '1;

  pwr_state_e        state_reg;
  pwr_state_e        state_next;
  logic [AW-1:0]     acc_reg;
  logic [AW-1:0]     acc_sum;
  logic [LOG2_N-1:0] win_cnt_reg;
  logic [DW-1:0]     avg_reg;
  logic [DW-1:0]     avg_new;
  logic [DW-1:0]     peak_reg;
  logic              avg_vld_reg;
  logic              accept;
  logic              win_done;
  logic              over;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (en)  state_next = ST_ACC;
      ST_ACC:  if (!en) state_next = ST_IDLE;
      default:          state_next = ST_IDLE;
    endcase
  end

  // Accumulator is wide enough for N full-scale samples, so the sum never wraps.
  assign accept   = (state_reg == ST_ACC) && en && sample_vld;
  assign win_done = accept && (win_cnt_reg == LAST);
  assign acc_sum  = acc_reg + AW'(sample_in);
  assign avg_new  = acc_sum[AW-1:LOG2_N];
  assign over     = avg_new > thr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      win_cnt_reg <= '0;
      avg_reg     <= '0;
      avg_vld_reg <= 1'b0;
    end else begin
      avg_vld_reg <= win_done;
      if (!en) begin
        acc_reg     <= '0;
        win_cnt_reg <= '0;
      end else if (win_done) begin
        acc_reg     <= '0;
        win_cnt_reg <= '0;
        avg_reg     <= avg_new;
      end else if (accept) begin
        acc_reg     <= acc_sum;
        win_cnt_reg <= win_cnt_reg + LOG2_N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_reg <= '0;
    end else if (state_reg == ST_ACC) begin
      if (peak_clr)
        peak_reg <= accept ? sample_in : '0;
      else if (accept && (sample_in > peak_reg))
        peak_reg <= sample_in;
    end
  end

  pwr_alarm_deb #(
    .OVER_CNT (OVER_CNT)
  ) u_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .win_done  (win_done),
    .over      (over),
    .alarm_clr (alarm_clr),
    .en        (en),
    .alarm     (alarm)
  );

  assign avg_out  = avg_reg;
  assign avg_vld  = avg_vld_reg;
  assign peak_out = peak_reg;
  assign win_cnt  = win_cnt_reg;

endmodule
